// File: rtl/multicycle_controller.sv
// Multicycle RV32 subset control FSM: fetch, decode, execute, memory and
// writeback sequencing with optional memory handshake and blt/bge support.
module multicycle_controller #(
    parameter int MEM_HANDSHAKE = 1,
    parameter int EN_BLT_BGE    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       zero,
    input  logic       negative,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       old_pc_write,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       adr_sel,
    output logic [2:0] extend_func,
    output logic [1:0] alu_sel_a,
    output logic [1:0] alu_sel_b,
    output logic [2:0] aluop,
    output logic [1:0] result_sel,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WB   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_ALU_WB   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LINK     = 4'd12,
        S_LUI      = 4'd13,
        S_TRAP     = 4'd14
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b110;

    localparam logic [2:0] EXT_I = 3'b000;
    localparam logic [2:0] EXT_S = 3'b001;
    localparam logic [2:0] EXT_B = 3'b010;
    localparam logic [2:0] EXT_J = 3'b011;
    localparam logic [2:0] EXT_U = 3'b100;

    state_t     r_state;
    logic       r_illegal;
    state_t     w_next;
    logic       w_mem_done;
    logic       w_pc_write;
    logic       w_ir_write;
    logic       w_old_pc_write;
    logic       w_reg_write;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_adr_sel;
    logic [2:0] w_extend;
    logic [1:0] w_sel_a;
    logic [1:0] w_sel_b;
    logic [2:0] w_aluop;
    logic [1:0] w_result;

    assign w_mem_done = (MEM_HANDSHAKE == 0) ? 1'b1 : mem_ready;

    always_comb begin
        w_next         = r_state;
        w_pc_write     = 1'b0;
        w_ir_write     = 1'b0;
        w_old_pc_write = 1'b0;
        w_reg_write    = 1'b0;
        w_mem_read     = 1'b0;
        w_mem_write    = 1'b0;
        w_adr_sel      = 1'b0;
        w_extend       = EXT_I;
        w_sel_a        = 2'b00;
        w_sel_b        = 2'b00;
        w_aluop        = ALU_ADD;
        w_result       = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_mem_read = 1'b1;
                w_sel_b    = 2'b10;
                w_result   = 2'b10;
                if (w_mem_done) begin
                    w_ir_write     = 1'b1;
                    w_old_pc_write = 1'b1;
                    w_pc_write     = 1'b1;
                    w_next         = S_DECODE;
                end
            end
            S_DECODE: begin
                w_sel_a  = 2'b01;
                w_sel_b  = 2'b01;
                w_extend = (op == OP_BR) ? EXT_B : EXT_J;
                case (op)
                    OP_R:     w_next = S_EXEC_R;
                    OP_I:     w_next = S_EXEC_I;
                    OP_LOAD,
                    OP_STORE: w_next = S_MEM_ADDR;
                    OP_BR:    w_next = S_BRANCH;
                    OP_JAL:   w_next = S_JAL;
                    OP_JALR:  w_next = S_JALR;
                    OP_LUI:   w_next = S_LUI;
                    default:  w_next = S_TRAP;
                endcase
            end
            S_EXEC_R: begin
                w_sel_a = 2'b10;
                w_next  = S_ALU_WB;
                if (func7 == 7'b0000000) begin
                    case (func3)
                        3'b000:  w_aluop = ALU_ADD;
                        3'b010:  w_aluop = ALU_SLT;
                        3'b100:  w_aluop = ALU_XOR;
                        3'b110:  w_aluop = ALU_OR;
                        3'b111:  w_aluop = ALU_AND;
                        default: w_next  = S_TRAP;
                    endcase
                end else if (func7 == 7'b0100000 && func3 == 3'b000) begin
                    w_aluop = ALU_SUB;
                end else begin
                    w_next = S_TRAP;
                end
            end
            S_EXEC_I: begin
                w_sel_a = 2'b10;
                w_sel_b = 2'b01;
                w_next  = S_ALU_WB;
                case (func3)
                    3'b000:  w_aluop = ALU_ADD;
                    3'b010:  w_aluop = ALU_SLT;
                    3'b100:  w_aluop = ALU_XOR;
                    3'b110:  w_aluop = ALU_OR;
                    3'b111:  w_aluop = ALU_AND;
                    default: w_next  = S_TRAP;
                endcase
            end
            S_MEM_ADDR: begin
                w_sel_a  = 2'b10;
                w_sel_b  = 2'b01;
                w_extend = (op == OP_STORE) ? EXT_S : EXT_I;
                if (func3 != 3'b010)
                    w_next = S_TRAP;
                else if (op == OP_STORE)
                    w_next = S_MEM_WR;
                else
                    w_next = S_MEM_RD;
            end
            S_MEM_RD: begin
                w_mem_read = 1'b1;
                w_adr_sel  = 1'b1;
                if (w_mem_done)
                    w_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                w_reg_write = 1'b1;
                w_result    = 2'b01;
                w_next      = S_FETCH;
            end
            S_MEM_WR: begin
                w_mem_write = 1'b1;
                w_adr_sel   = 1'b1;
                if (w_mem_done)
                    w_next = S_FETCH;
            end
            S_ALU_WB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                w_sel_a = 2'b10;
                w_aluop = ALU_SUB;
                w_next  = S_FETCH;
                case (func3)
                    3'b000: w_pc_write = zero;
                    3'b001: w_pc_write = ~zero;
                    3'b100: begin
                        if (EN_BLT_BGE != 0)
                            w_pc_write = negative;
                        else
                            w_next = S_TRAP;
                    end
                    3'b101: begin
                        if (EN_BLT_BGE != 0)
                            w_pc_write = ~negative;
                        else
                            w_next = S_TRAP;
                    end
                    default: w_next = S_TRAP;
                endcase
            end
            S_JAL: begin
                w_pc_write = 1'b1;
                w_next     = S_LINK;
            end
            S_JALR: begin
                w_sel_a  = 2'b10;
                w_sel_b  = 2'b01;
                w_result = 2'b10;
                // An illegal jalr must not redirect the pc on its way to TRAP
                if (func3 == 3'b000) begin
                    w_pc_write = 1'b1;
                    w_next     = S_LINK;
                end else begin
                    w_next = S_TRAP;
                end
            end
            S_LINK: begin
                w_sel_a     = 2'b01;
                w_sel_b     = 2'b10;
                w_result    = 2'b10;
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_LUI: begin
                w_extend    = EXT_U;
                w_result    = 2'b11;
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next == S_TRAP)
                r_illegal <= 1'b1;
        end
    end

    // Reset overrides every side-effecting enable so an abandoned
    // instruction cannot write anything while rst is held.
    assign pc_write     = w_pc_write & ~rst;
    assign ir_write     = w_ir_write & ~rst;
    assign old_pc_write = w_old_pc_write & ~rst;
    assign reg_write    = w_reg_write & ~rst;
    assign mem_read     = w_mem_read & ~rst;
    assign mem_write    = w_mem_write & ~rst;
    assign instr_done   = ~rst & (r_state != S_FETCH) & (w_next == S_FETCH);
    assign adr_sel      = w_adr_sel;
    assign extend_func  = w_extend;
    assign alu_sel_a    = w_sel_a;
    assign alu_sel_b    = w_sel_b;
    assign aluop        = w_aluop;
    assign result_sel   = w_result;
    assign state        = r_state;
    assign illegal      = r_illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-instruction traces with a
// latency scoreboard, plus a second instance built without blt/bge.
module tb_multicycle_controller;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = '0;
    logic [2:0] func3 = '0;
    logic [6:0] func7 = '0;
    logic       zero = 1'b0;
    logic       negative = 1'b0;
    logic       mem_ready = 1'b1;

    logic       pc_write, ir_write, old_pc_write, reg_write;
    logic       mem_read, mem_write, adr_sel, instr_done, illegal;
    logic [2:0] extend_func, aluop;
    logic [1:0] alu_sel_a, alu_sel_b, result_sel;
    logic [3:0] state;

    logic       pc_write_b, ir_write_b, old_pc_write_b, reg_write_b;
    logic       mem_read_b, mem_write_b, adr_sel_b, instr_done_b, illegal_b;
    logic [2:0] extend_func_b, aluop_b;
    logic [1:0] alu_sel_a_b, alu_sel_b_b, result_sel_b;
    logic [3:0] state_b;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7),
        .zero(zero), .negative(negative), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write),
        .old_pc_write(old_pc_write), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .adr_sel(adr_sel),
        .extend_func(extend_func), .alu_sel_a(alu_sel_a),
        .alu_sel_b(alu_sel_b), .aluop(aluop), .result_sel(result_sel),
        .state(state), .instr_done(instr_done), .illegal(illegal)
    );

    multicycle_controller #(.MEM_HANDSHAKE(1), .EN_BLT_BGE(0)) dut_b (
        .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7),
        .zero(zero), .negative(negative), .mem_ready(mem_ready),
        .pc_write(pc_write_b), .ir_write(ir_write_b),
        .old_pc_write(old_pc_write_b), .reg_write(reg_write_b),
        .mem_read(mem_read_b), .mem_write(mem_write_b), .adr_sel(adr_sel_b),
        .extend_func(extend_func_b), .alu_sel_a(alu_sel_a_b),
        .alu_sel_b(alu_sel_b_b), .aluop(aluop_b), .result_sel(result_sel_b),
        .state(state_b), .instr_done(instr_done_b), .illegal(illegal_b)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          exp_q[$];
    logic [63:0] st_tr;
    logic [15:0] rw_tr, pc_tr, mr_tr, mw_tr, dn_tr, pcb_tr;
    logic [11:0] snap[16];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from FETCH; the expected latency is queued when
    // the instruction is issued and retired against the observed count.
    task automatic run(input string tag, input logic [6:0] o,
                       input logic [2:0] f3, input logic [6:0] f7,
                       input logic z, input logic n,
                       input logic [3:0] stall_st, input int n_stall,
                       input int lat);
        int   cnt = 0;
        int   stalls = 0;
        int   got;
        logic done = 1'b0;
        op = o; func3 = f3; func7 = f7; zero = z; negative = n;
        exp_q.push_back(lat);
        st_tr = '0; rw_tr = '0; pc_tr = '0; mr_tr = '0;
        mw_tr = '0; dn_tr = '0; pcb_tr = '0;
        for (int i = 0; i < 16; i++) snap[i] = '0;
        while (!done && cnt < 16) begin
            mem_ready = !(state == stall_st && stalls < n_stall);
            if (!mem_ready) stalls++;
            @(negedge clk);
            st_tr[cnt*4 +: 4] = state;
            rw_tr[cnt]  = reg_write;
            pc_tr[cnt]  = pc_write;
            mr_tr[cnt]  = mem_read;
            mw_tr[cnt]  = mem_write;
            dn_tr[cnt]  = instr_done;
            pcb_tr[cnt] = pc_write_b;
            snap[cnt] = {extend_func, alu_sel_a, alu_sel_b, aluop, result_sel};
            done = instr_done;
            cnt++;
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b1;
        chk({tag, " done"}, 64'(done), 64'd1);
        got = exp_q.pop_front();
        chk({tag, " latency"}, 64'(cnt), 64'(got));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("reset state", 64'(state), 64'd0);
        chk("reset illegal", 64'(illegal), 64'd0);
        chk("reset enables", 64'({pc_write, ir_write, old_pc_write, mem_read}), 64'd0);
        chk("reset done", 64'(instr_done), 64'd0);
        chk("reset state_b", 64'(state_b), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run("add", OP_R, 3'b000, 7'h00, 1'b0, 1'b0, 4'd0, 0, 4);
        chk("add states", st_tr, 64'h8210);
        chk("add reg_write", 64'(rw_tr), 64'h8);
        chk("add pc_write", 64'(pc_tr), 64'h1);
        chk("add instr_done", 64'(dn_tr), 64'h8);
        chk("add fetch ctl", 64'(snap[0]), 64'({3'b000, 2'b00, 2'b10, 3'b000, 2'b10}));
        chk("add decode ctl", 64'(snap[1]), 64'({3'b011, 2'b01, 2'b01, 3'b000, 2'b00}));
        chk("add exec ctl", 64'(snap[2]), 64'({3'b000, 2'b10, 2'b00, 3'b000, 2'b00}));
        chk("add back to fetch", 64'(state), 64'd0);

        run("sub", OP_R, 3'b000, 7'h20, 1'b0, 1'b0, 4'd0, 0, 4);
        chk("sub aluop", 64'(snap[2]), 64'({3'b000, 2'b10, 2'b00, 3'b001, 2'b00}));
        run("xor", OP_R, 3'b100, 7'h00, 1'b0, 1'b0, 4'd0, 0, 4);
        chk("xor aluop", 64'(snap[2]), 64'({3'b000, 2'b10, 2'b00, 3'b110, 2'b00}));
        run("or", OP_R, 3'b110, 7'h00, 1'b0, 1'b0, 4'd0, 0, 4);
        chk("or aluop", 64'(snap[2]), 64'({3'b000, 2'b10, 2'b00, 3'b011, 2'b00}));
        run("slti", OP_I, 3'b010, 7'h00, 1'b0, 1'b0, 4'd0, 0, 4);
        chk("slti states", st_tr, 64'h8310);
        chk("slti ctl", 64'(snap[2]), 64'({3'b000, 2'b10, 2'b01, 3'b100, 2'b00}));
        run("andi", OP_I, 3'b111, 7'h00, 1'b0, 1'b0, 4'd0, 0, 4);
        chk("andi aluop", 64'(snap[2]), 64'({3'b000, 2'b10, 2'b01, 3'b010, 2'b00}));

        run("lw", OP_LOAD, 3'b010, 7'h00, 1'b0, 1'b0, 4'd5, 2, 7);
        chk("lw states", st_tr, 64'h6555410);
        chk("lw mem_read", 64'(mr_tr), 64'h39);
        chk("lw reg_write", 64'(rw_tr), 64'h40);
        chk("lw addr ctl", 64'(snap[2]), 64'({3'b000, 2'b10, 2'b01, 3'b000, 2'b00}));
        chk("lw wb ctl", 64'(snap[6]), 64'({3'b000, 2'b00, 2'b00, 3'b000, 2'b01}));

        run("sw", OP_STORE, 3'b010, 7'h00, 1'b0, 1'b0, 4'd7, 1, 5);
        chk("sw states", st_tr, 64'h77410);
        chk("sw mem_write", 64'(mw_tr), 64'h18);
        chk("sw reg_write", 64'(rw_tr), 64'h0);
        chk("sw addr ctl", 64'(snap[2]), 64'({3'b001, 2'b10, 2'b01, 3'b000, 2'b00}));

        run("fetch stall", OP_R, 3'b000, 7'h00, 1'b0, 1'b0, 4'd0, 1, 5);
        chk("fetch stall states", st_tr, 64'h82100);
        chk("fetch stall pc_write", 64'(pc_tr), 64'h2);

        run("beq taken", OP_BR, 3'b000, 7'h00, 1'b1, 1'b0, 4'd0, 0, 3);
        chk("beq states", st_tr, 64'h910);
        chk("beq pc_write", 64'(pc_tr), 64'h5);
        chk("beq decode ctl", 64'(snap[1]), 64'({3'b010, 2'b01, 2'b01, 3'b000, 2'b00}));
        chk("beq branch ctl", 64'(snap[2]), 64'({3'b000, 2'b10, 2'b00, 3'b001, 2'b00}));
        run("bne not taken", OP_BR, 3'b001, 7'h00, 1'b1, 1'b0, 4'd0, 0, 3);
        chk("bne pc_write", 64'(pc_tr), 64'h1);
        run("bne taken", OP_BR, 3'b001, 7'h00, 1'b0, 1'b0, 4'd0, 0, 3);
        chk("bne taken pc_write", 64'(pc_tr), 64'h5);

        run("blt taken", OP_BR, 3'b100, 7'h00, 1'b0, 1'b1, 4'd0, 0, 3);
        chk("blt pc_write", 64'(pc_tr), 64'h5);
        chk("blt_b pc_write", 64'(pcb_tr), 64'h1);
        chk("blt_b trap", 64'(state_b), 64'd14);
        chk("blt_b illegal", 64'(illegal_b), 64'd1);
        step(); step(); step();
        chk("blt_b trap sticky", 64'(state_b), 64'd14);
        chk("blt_b illegal sticky", 64'(illegal_b), 64'd1);
        do_reset();
        chk("blt_b reset state", 64'(state_b), 64'd0);
        chk("blt_b reset illegal", 64'(illegal_b), 64'd0);

        run("bge not taken", OP_BR, 3'b101, 7'h00, 1'b0, 1'b1, 4'd0, 0, 3);
        chk("bge n1 pc_write", 64'(pc_tr), 64'h1);
        run("bge taken", OP_BR, 3'b101, 7'h00, 1'b0, 1'b0, 4'd0, 0, 3);
        chk("bge n0 pc_write", 64'(pc_tr), 64'h5);

        run("jal", OP_JAL, 3'b000, 7'h00, 1'b0, 1'b0, 4'd0, 0, 4);
        chk("jal states", st_tr, 64'hCA10);
        chk("jal pc_write", 64'(pc_tr), 64'h5);
        chk("jal reg_write", 64'(rw_tr), 64'h8);
        chk("jal link ctl", 64'(snap[3]), 64'({3'b000, 2'b01, 2'b10, 3'b000, 2'b10}));

        run("jalr", OP_JALR, 3'b000, 7'h00, 1'b0, 1'b0, 4'd0, 0, 4);
        chk("jalr states", st_tr, 64'hCB10);
        chk("jalr pc_write", 64'(pc_tr), 64'h5);
        chk("jalr ctl", 64'(snap[2]), 64'({3'b000, 2'b10, 2'b01, 3'b000, 2'b10}));

        run("lui", OP_LUI, 3'b000, 7'h00, 1'b0, 1'b0, 4'd0, 0, 3);
        chk("lui states", st_tr, 64'hD10);
        chk("lui reg_write", 64'(rw_tr), 64'h4);
        chk("lui ctl", 64'(snap[2]), 64'({3'b100, 2'b00, 2'b00, 3'b000, 2'b11}));

        op = 7'b0000000; func3 = 3'b000; func7 = 7'h00;
        step(); step();
        chk("bad op trap", 64'(state), 64'd14);
        chk("bad op illegal", 64'(illegal), 64'd1);
        do_reset();
        chk("bad op reset", 64'(illegal), 64'd0);

        op = OP_R; func3 = 3'b001; func7 = 7'h00;
        step(); step(); step();
        chk("bad func3 trap", 64'(state), 64'd14);
        do_reset();

        op = OP_JALR; func3 = 3'b001; func7 = 7'h00;
        step(); step();
        @(negedge clk);
        chk("bad jalr pc_write", 64'(pc_write), 64'd0);
        @(posedge clk);
        #1;
        chk("bad jalr trap", 64'(state), 64'd14);
        do_reset();

        op = OP_STORE; func3 = 3'b010; func7 = 7'h00;
        step(); step();
        mem_ready = 1'b0;
        step();
        @(negedge clk);
        chk("sw stall state", 64'(state), 64'd7);
        chk("sw stall mem_write", 64'(mem_write), 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("sw stall held", 64'(mem_write), 64'd1);
        rst = 1'b1;
        #1;
        chk("sw rst mem_write", 64'(mem_write), 64'd0);
        chk("sw rst done", 64'(instr_done), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("sw rst state", 64'(state), 64'd0);
        @(negedge clk);
        chk("sw after mem_write", 64'(mem_write), 64'd0);
        mem_ready = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

endmodule
